seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display. Holds an N-digit hex value, cycles one shared `hex7seg` decoder across the digits at a programmable refresh rate, and drives a one-hot digit enable with an anti-ghosting blank interval. It sits between the datapath that produces the displayed value and the board display pins. Updates are applied only at frame boundaries, so the display never tears.

---
 rtl/seg_pkg.sv | 14 +
 rtl/hex7seg.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared widths, constants and slot-phase type for the 7-segment scan controller.
package seg_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-7-segment decoder; segments a..g with a as MSB, active-high.
module hex7seg
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with frame-synchronous shadow update.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            value_valid,
    output logic                            value_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0]  value_data,
    output logic [SEG_W-1:0]                seg,
    output logic [NUM_DIGITS-1:0]           digit_en,
    output logic [$clog2(NUM_DIGITS)-1:0]   scan_idx,
    output logic                            frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int DATA_W = NIBBLE_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      SLOT_PRE  = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE    = NUM_DIGITS'(1);

    logic [DATA_W-1:0]   disp_reg;
    logic [DATA_W-1:0]   pend_reg;
    logic                pend_flag;
    logic [CNT_W-1:0]    slot_cnt;
    phase_t              phase;
    logic                slot_end;
    logic                frame_end;
    logic                accept;
    logic [NIBBLE_W-1:0] cur_nibble;
    logic [SEG_W-1:0]    dec_seg;
    logic                lz_blank;

    assign value_ready = rst_n && !pend_flag;
    assign accept      = value_valid && value_ready;
    assign slot_end    = (slot_cnt == SLOT_LAST);
    assign frame_end   = slot_end && (scan_idx == IDX_LAST);
    assign phase       = (slot_cnt < BLANK_END) ? PH_BLANK : PH_ON;

    always_comb begin
        cur_nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nibble = disp_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // Digit 0 is never a leading zero, so the search starts at digit 1.
    logic [IDX_W-1:0] msd_idx;

    always_comb begin
        msd_idx = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_reg[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                msd_idx = IDX_W'(i);
            end
        end
    end

    assign lz_blank = (scan_idx > msd_idx);
`else
    assign lz_blank = 1'b0;
`endif

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // frame_done is predicted one cycle early so the registered pulse lands on the boundary cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt   <= '0;
            scan_idx   <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_flag  <= 1'b0;
            seg        <= SEG_BLANK;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end

            frame_done <= (slot_cnt == SLOT_PRE) && (scan_idx == IDX_LAST);

            if (frame_end && pend_flag) begin
                disp_reg  <= pend_reg;
                pend_flag <= 1'b0;
            end else if (accept) begin
                pend_reg  <= value_data;
                pend_flag <= 1'b1;
            end

            digit_en <= (phase == PH_ON) ? (EN_ONE << scan_idx) : '0;
            seg      <= lz_blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
// Expected display contents are queued on acceptance and popped at the frame boundary that applies them.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        value_valid = 1'b0;
    logic [15:0] value_data = '0;
    logic        value_ready;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic [1:0]  scan_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .value_data  (value_data),
        .seg         (seg),
        .digit_en    (digit_en),
        .scan_idx    (scan_idx),
        .frame_done  (frame_done)
    );

    typedef logic [3:0][6:0] codes_t;
    typedef struct {
        logic [15:0] value;
        codes_t      code;
    } vec_t;

    vec_t   vecs [6];
    codes_t exp_q [$];
    codes_t cur_disp;
    codes_t prev_disp;
    int     n;
    bit     in_reset;
    bit     m_pend;
    int     compared = 0;
    int     mismatched = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic check_output();
        int p;
        int pidx;
        if (in_reset) begin
            check("reset_seg", 32'(seg), 0);
            check("reset_digit_en", 32'(digit_en), 0);
            check("reset_value_ready", 32'(value_ready), 0);
            check("reset_frame_done", 32'(frame_done), 0);
            check("reset_scan_idx", 32'(scan_idx), 0);
            return;
        end
        check("value_ready", 32'(value_ready), 32'(!m_pend));
        check("frame_done", 32'(frame_done), 32'((n % FRAME) == FRAME - 1));
        check("scan_idx", 32'(scan_idx), 32'((n / RD) % ND));
        if (n == 0) begin
            check("seg_first", 32'(seg), 0);
            check("digit_en_first", 32'(digit_en), 0);
        end else begin
            p    = n - 1;
            pidx = (p / RD) % ND;
            check("digit_en", 32'(digit_en), ((p % RD) >= BC) ? (32'd1 << pidx) : 32'd0);
            check("seg", 32'(seg), 32'(prev_disp[pidx]));
        end
    endtask

    // Drive one cycle's inputs, advance the reference state across the edge, then check.
    task automatic apply_stimulus(bit v, int k, bit r);
        value_valid = v;
        value_data  = v ? vecs[k].value : 16'($urandom);
        rst_n       = r;
        if (r && in_reset) begin
            in_reset = 1'b0;
            n        = 0;
            #1;
            check("ready_after_release", 32'(value_ready), 1);
        end
        if (!r) begin
            in_reset  = 1'b1;
            m_pend    = 1'b0;
            exp_q.delete();
            cur_disp  = vecs[0].code;
            prev_disp = vecs[0].code;
        end else begin
            prev_disp = cur_disp;
            if ((n % FRAME) == FRAME - 1 && m_pend) begin
                cur_disp = exp_q.pop_front();
                m_pend   = 1'b0;
            end else if (v && !m_pend) begin
                exp_q.push_back(vecs[k].code);
                m_pend = 1'b1;
            end
            n++;
        end
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 0, 1'b1);
    endtask

    task automatic idle_until_phase(int ph);
        int guard = 0;
        while ((n % FRAME) != ph && guard < 2 * FRAME) begin
            apply_stimulus(1'b0, 0, 1'b1);
            guard++;
        end
    endtask

    task automatic load(int k);
        int guard = 0;
        bit was_pend;
        do begin
            was_pend = m_pend;
            apply_stimulus(1'b1, k, 1'b1);
            guard++;
        end while (was_pend && guard < 3 * FRAME);
        if (was_pend) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL load_timeout for vector %0d", k);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", n);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
`ifdef SEG_SCAN_LZB_EN
        vecs[0] = '{value: 16'h0000, code: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vecs[5] = '{value: 16'h0005, code: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1011011}};
`else
        vecs[0] = '{value: 16'h0000, code: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[5] = '{value: 16'h0005, code: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1011011}};
`endif
        vecs[1] = '{value: 16'h12AF, code: {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}};
        vecs[2] = '{value: 16'h1111, code: {7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000}};
        vecs[3] = '{value: 16'h2222, code: {7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101}};
        vecs[4] = '{value: 16'hBEEF, code: {7'b0011111, 7'b1001111, 7'b1001111, 7'b1000111}};

        in_reset  = 1'b1;
        m_pend    = 1'b0;
        n         = 0;
        cur_disp  = vecs[0].code;
        prev_disp = vecs[0].code;

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, 1'b1);

        idle(4);
        load(1);
        idle(2 * FRAME + 4);

        idle_until_phase(10);
        load(2);
        load(3);
        idle(2 * FRAME + 4);

        idle_until_phase(FRAME - 1);
        load(4);
        idle(2 * FRAME + 4);

        for (int k = 5; k >= 0; k -= 5) begin
            idle_until_phase(13);
            load(k);
            idle(2 * FRAME + 4);
        end

        idle_until_phase(12);
        load(2);
        idle(3);
        apply_stimulus(1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, 1'b1);
        idle(2 * FRAME + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
